lsu_req_queue: RTL
==================

# lsu_req_queue

Parametrised load/store request unit between the execute and memory stages. Takes one memory op per handshake and checks alignment. Builds byte strobes and replicated write data, then issues on the SRAM-like data bus. Up to DEPTH bus requests can be outstanding at once; they are tracked in order, with load extraction and sign extension done on return. Flush cancels pending work while still absorbing in-flight bus responses.

## Interface
- DATA_W, 32: bus data width, 32 or 64; LANES = DATA_W/8, OFF_W = log2(LANES)
- DEPTH, 4: max outstanding bus transactions, power of two, ≥1; CNT_W = log2(DEPTH)+1
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  op offered by EXE
- in_ready  out  1  op accepted when in_valid & in_ready
- in_load  in  1  op is a load (else store)
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword
- in_unsigned  in  1  zero-extend load result
- in_addr  in  32  byte address
- in_wdata  in  DATA_W  store data, right-aligned
- in_dest  in  5  destination register, passed through
- flush  in  1  exception/ertn flush from WB
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  = in_size
- data_wstrb  out  LANES  byte enables, 0 for loads
- data_addr  out  32  = in_addr
- data_wdata  out  DATA_W  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response (reads and writes), in order
- data_rdata  in  DATA_W  read data
- rsp_valid  out  1  result for MEM stage
- rsp_ready  in  1  MEM accepts
- rsp_data  out  DATA_W  extended load data, 0 for stores
- rsp_dest  out  5  in_dest of op
- rsp_is_load  out  1  op was a load
- rsp_ale  out  1  alignment exception, no bus access made
- outstanding  out  CNT_W  live queue entries + cancelled in-flight

## Operation
- ale = (in_size > OFF_W) | (in_addr & ((1<<in_size)-1) != 0).
- Normal op: data_req = in_valid & ~ale & ~full & ~flush & ~ex_v. Accept = data_req & data_addr_ok. On accept, an entry {load, size, unsigned, off=in_addr[OFF_W-1:0], dest, done=0} is written at tail.
- full = (count + cancel_cnt == DEPTH), using registered values. A same-cycle pop does not free a slot.
- ALE op: in_ready = queue empty & cancel_cnt==0 & ~ex_v & ~flush. It is captured in ex register (ex_v=1); no bus access.
- in_ready = normal ? data_addr_ok & data_req : ALE accept condition.
- data_wstrb = ((1<<(1<<size))-1) << off for stores.
- data_wdata = in_wdata low 2^size bytes replicated across LANES.
- data_data_ok with cancel_cnt>0: decrement cancel_cnt, discard data.
- Otherwise it completes the oldest not-done entry (dptr):
  - Store: data = 0.
  - Load: rdata >> (8*off), masked to 2^size bytes, sign- or zero-extended to DATA_W.
  - Set done.
- Response: rsp_valid = head.done, or ex_v when queue empty. Pop on rsp_valid & rsp_ready.
- flush:
  - cancel_cnt <= (issued not-done entries) − (data_ok this cycle ? 1 : 0).
  - Queue emptied, ex_v cleared, dptr = head = tail.
  - in_ready, data_req, rsp_valid forced 0 that cycle.
- data_data_ok with nothing pending is a protocol error; the state is unchanged.

## Timing
- Reset: count, cancel_cnt, pointers, ex_v = 0. rsp_valid=0, in_ready=0 until in_valid, outstanding=0; data_req follows in_valid.
- in_ready and data_req are combinational from in_valid/in_addr/data_addr_ok and registered state.
- data_data_ok in cycle N → rsp_valid in N+1 if that entry is head.
- ALE accepted in N → rsp_valid/rsp_ale in N+1.
- Throughput: 1 accept/cycle while not full. With DEPTH full, the next accept comes no earlier than the cycle after a pop.
- Accept, data_ok and pop may all occur in one cycle. count updates by +accept −pop.
- resetn low mid-transfer: all state cleared immediately; bus responses still pending are the system's responsibility.

## Test plan
- DATA_W=32: ld.b addr 0x1003, rdata 0x80FF_1234 → data_wstrb 0, rsp_data 0xFFFF_FF80; ld.bu → 0x0000_0080; response 1 cycle after data_ok.
- st.h addr 0x2002, wdata 0xABCD → data_wstrb 4'b1100, data_wdata 0xABCD_ABCD, rsp_is_load=0.
- DEPTH=4: 5 loads back-to-back, addr_ok=1, no data_ok → 4 accepted, 5th held (in_ready=0), outstanding=4; data_ok ×4 returns in order.
- ld.w addr 0x1002 with 2 loads in flight → in_ready=0 until both respond and pop; then rsp_ale=1, no data_req.
- 3 loads in flight, flush coincides with 1 data_ok → cancel_cnt=2, rsp_valid never asserted for them; new load issued next cycle, its data returns as 3rd data_ok and is delivered.
- DATA_W=64: ld.d addr 0x8 → wstrb 0, full 64-bit rdata returned; ld.d addr 0x4 → ale; size 3 at DATA_W=32 → ale.

Source files
------------

// File: rtl/lsu_req_queue.sv
// In-order load/store request queue between EXE and MEM.
// Issues on an SRAM-like bus; flush drains in-flight responses.
module lsu_req_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_dest,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [LANES-1:0]  data_wstrb,
  output logic [31:0]       data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_dest,
  output logic              rsp_is_load,
  output logic              rsp_ale,
  output logic [CNT_W-1:0]  outstanding
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH;

  typedef struct packed {
    logic              ld;
    logic [1:0]        size;
    logic              uns;
    logic [OFF_W-1:0]  off;
    logic [4:0]        dest;
    logic              done;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] dptr_q, dptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic ex_v_q, ex_v_d;
  logic ex_load_q, ex_load_d;
  logic [4:0] ex_dest_q, ex_dest_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] amask;
  logic ale, full, empty, ale_acc, accept;
  logic ok_cancel, ok_done, pop, pop_ent, pop_ex;
  logic [DATA_W-1:0] shifted, ld_data;
  logic sgn;
  ent_t de, he;
  int nb, off, rb;

  assign empty = (count_q == '0);
  assign de = ent_q[dptr_q];
  assign he = ent_q[head_q];

  always_comb begin
    amask = (32'd1 << in_size) - 32'd1;
    ale = (int'(in_size) > OFF_W) | ((in_addr & amask) != 32'd0);
    full = ({1'b0, count_q} + {1'b0, cancel_q}) == DEPTH_C;
    data_req = in_valid & ~ale & ~full & ~flush & ~ex_v_q;
    ale_acc = in_valid & ale & empty & (cancel_q == '0)
            & ~ex_v_q & ~flush;
    accept = data_req & data_addr_ok;
    in_ready = ale ? ale_acc : accept;
  end

  assign data_wr   = ~in_load;
  assign data_size = in_size;
  assign data_addr = in_addr;

  // Strobes cover 2^size bytes from the offset; data repeats per chunk
  always_comb begin
    nb = 1 << in_size;
    off = int'(in_addr[OFF_W-1:0]);
    data_wstrb = '0;
    data_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      data_wstrb[i] = ~in_load && (i >= off) && (i < off + nb);
      data_wdata[8*i +: 8] = in_wdata[8*(i & (nb - 1)) +: 8];
    end
  end

  always_comb begin
    shifted = data_rdata >> {de.off, 3'b000};
    rb = 1 << de.size;
    sgn = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (i == rb - 1) sgn = ~de.uns & shifted[8*i + 7];
    ld_data = '0;
    for (int i = 0; i < LANES; i++)
      ld_data[8*i +: 8] = (i < rb) ? shifted[8*i +: 8] : {8{sgn}};
    if (!de.ld) ld_data = '0;
  end

  always_comb begin
    rsp_valid   = ~flush & (empty ? ex_v_q : he.done);
    rsp_data    = empty ? '0 : he.data;
    rsp_dest    = empty ? ex_dest_q : he.dest;
    rsp_is_load = empty ? ex_load_q : he.ld;
    rsp_ale     = empty & ex_v_q;
    outstanding = count_q + cancel_q;
  end

  always_comb begin
    ok_cancel = data_data_ok & (cancel_q != '0);
    ok_done   = data_data_ok & (cancel_q == '0) & (pend_q != '0);
    pop       = rsp_valid & rsp_ready;
    pop_ent   = pop & ~empty;
    pop_ex    = pop & empty;
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    dptr_d    = dptr_q;
    count_d   = count_q;
    pend_d    = pend_q;
    cancel_d  = cancel_q;
    ex_v_d    = ex_v_q;
    ex_load_d = ex_load_q;
    ex_dest_d = ex_dest_q;
    if (flush) begin
      // Everything issued but unanswered must still be absorbed
      cancel_d = cancel_q + pend_q
               - CNT_W'(data_data_ok && (cancel_q + pend_q) != '0);
      count_d = '0;
      pend_d  = '0;
      ex_v_d  = 1'b0;
      head_d  = tail_q;
      dptr_d  = tail_q;
    end else begin
      if (accept) begin
        ent_d[tail_q] = '{ld: in_load, size: in_size,
                          uns: in_unsigned,
                          off: in_addr[OFF_W-1:0],
                          dest: in_dest, done: 1'b0,
                          data: '0};
        tail_d = nxt(tail_q);
      end
      if (ok_cancel) cancel_d = cancel_q - 1'b1;
      if (ok_done) begin
        ent_d[dptr_q].done = 1'b1;
        ent_d[dptr_q].data = ld_data;
        dptr_d = nxt(dptr_q);
      end
      if (pop_ent) head_d = nxt(head_q);
      pend_d  = pend_q + CNT_W'(accept) - CNT_W'(ok_done);
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop_ent);
      if (ale_acc) begin
        ex_v_d    = 1'b1;
        ex_load_d = in_load;
        ex_dest_d = in_dest;
      end
      if (pop_ex) ex_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_q     <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      dptr_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      cancel_q  <= '0;
      ex_v_q    <= 1'b0;
      ex_load_q <= 1'b0;
      ex_dest_q <= '0;
    end else begin
      ent_q     <= ent_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      dptr_q    <= dptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      cancel_q  <= cancel_d;
      ex_v_q    <= ex_v_d;
      ex_load_q <= ex_load_d;
      ex_dest_q <= ex_dest_d;
    end
  end
endmodule
